debouncer: RTL and testbench
============================

// Module: debouncer
//
// PURPOSE
// Cleans a raw asynchronous level input (push-button, switch) into a glitch-free,
// clock-synchronous level for the edge_detector stage that sits directly downstream.
// Input passes a SYNC_STAGES-deep flop synchronizer, then a 4-state FSM with a
// stability counter; a new level is accepted only after it holds BOUNCE_TICKS+1
// consecutive synchronized samples. out feeds edge_detector's in port unchanged.
//
// PARAMETERS
// SYNC_STAGES   2  synchronizer depth; legal >= 2 (elaboration error otherwise)
// BOUNCE_TICKS  4  extra stable samples required after first change; legal >= 1
// RESET_LEVEL   0  value of out and all sync flops while rst is high
//
// PORTS
// clk   input  1  system clock; all state changes on posedge
// rst   input  1  asynchronous, active-high reset
// in    input  1  raw asynchronous level; no timing relationship to clk
// out   output 1  debounced synchronous level (registered, Moore)
// busy  output 1  high while a candidate level change is being qualified
//
// BEHAVIOUR
// - Reset: sync chain and out = RESET_LEVEL; state = STABLE_<RESET_LEVEL>; cnt = 0;
//   busy = 0. Takes effect immediately on rst rise, independent of clk.
// - Synchronizer: s = last stage of SYNC_STAGES flops; nothing but stage 1 sees in.
// - cnt width = $clog2(BOUNCE_TICKS+1); never exceeds BOUNCE_TICKS-1, never wraps.
// - FSM states and transitions, per posedge (s = synchronized input):
//   STABLE_LOW : s=1 -> MAYBE_HIGH, cnt<=0; else stay.
//   MAYBE_HIGH : s=0 -> STABLE_LOW (abort, cnt<=0);
//                s=1 & cnt==BOUNCE_TICKS-1 -> STABLE_HIGH, cnt<=0; s=1 else cnt++.
//   STABLE_HIGH: s=0 -> MAYBE_LOW, cnt<=0; else stay.
//   MAYBE_LOW  : s=1 -> STABLE_HIGH (abort, cnt<=0);
//                s=0 & cnt==BOUNCE_TICKS-1 -> STABLE_LOW, cnt<=0; s=0 else cnt++.
// - out = 1 in STABLE_HIGH or MAYBE_LOW, else 0 (old level held during qualification).
// - busy = 1 in MAYBE_HIGH or MAYBE_LOW only.
// - Latency: new level first sampled by stage 1 at edge k -> s changes at edge
//   k+SYNC_STAGES-1, busy rises at k+SYNC_STAGES, out changes at edge
//   k+SYNC_STAGES+BOUNCE_TICKS (6 with defaults); busy falls on that same edge.
// - Glitch rule: a change holding <= BOUNCE_TICKS samples at s never reaches out;
//   >= BOUNCE_TICKS+1 samples is always accepted. Abort restarts qualification fully.
// - out never toggles twice within BOUNCE_TICKS+1 cycles; out changes at most once
//   per accepted level, so edge_detector sees exactly one edge per accepted change.
// - rst asserted mid-qualification: pending change discarded, out = RESET_LEVEL;
//   after release, a held input is re-qualified from scratch (full latency).
// - Unreachable state encodings recover to STABLE_<RESET_LEVEL> next edge.
//
// TESTING (defaults: SYNC_STAGES=2, BOUNCE_TICKS=4, clk period 10)
// 1 Reset: rst=1, in=1 for 3 cycles -> out=0, busy=0; release with in=0 -> out stays 0.
// 2 Clean rise: in 0->1 before edge k, held -> busy=1 at k+2..k+5, out=1 at k+6, busy=0.
// 3 Glitch: in=1 for exactly 4 cycles then 0 -> out stays 0; busy high 4 cycles then 0.
// 4 Minimum pulse: in=1 for 5 cycles -> out=1 at k+6; falls 6 edges after in falls.
// 5 Bounce train: in toggles every 2 cycles x10, then held 1 -> out rises once,
//   exactly 6 edges after the final toggle; downstream positive_edge pulses once.
// 6 Reset mid-MAYBE_HIGH (edge k+4): out=0, busy=0 immediately; in still 1 after
//   release -> out=1 exactly 6 edges after first post-reset sampling edge.

Source files
------------

// File: rtl/debouncer.sv
// Debouncer: multi-flop synchronizer followed by a four-state qualification FSM.
// A new level reaches out only after it has been seen on the synchronized input
// for BOUNCE_TICKS+1 consecutive clocks; shorter excursions are discarded.
module debouncer #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned BOUNCE_TICKS = 4,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
);

  localparam int unsigned CntW = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BOUNCE_TICKS - 1);

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debouncer: SYNC_STAGES must be >= 2");
  end
  if (BOUNCE_TICKS < 1) begin : g_bad_ticks
    $error("debouncer: BOUNCE_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    StStableLow  = 2'b00,
    StMaybeHigh  = 2'b01,
    StStableHigh = 2'b10,
    StMaybeLow   = 2'b11
  } state_e;

  localparam state_e StReset = RESET_LEVEL ? StStableHigh : StStableLow;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  // Synchronizer shift: only stage 0 ever looks at the raw input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
    s      = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer chain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Qualification FSM next-state and stability counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StStableLow: begin
        if (s) begin
          state_d = StMaybeHigh;
          cnt_d   = '0;
        end
      end
      StMaybeHigh: begin
        if (!s) begin
          // Abort: the excursion was too short, start over from the old level.
          state_d = StStableLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStableHigh: begin
        if (!s) begin
          state_d = StMaybeLow;
          cnt_d   = '0;
        end
      end
      StMaybeLow: begin
        if (s) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StReset;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReset;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs: the old level is held while a change is being qualified.
  always_comb begin
    out  = (state_q == StStableHigh) || (state_q == StMaybeLow);
    busy = (state_q == StMaybeHigh) || (state_q == StMaybeLow);
  end

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: directed scenarios plus random bounce trains, checked every
// cycle against a run-length model of the debounce rule.
module tb_debouncer;

  localparam int unsigned SS = 2;
  localparam int unsigned BT = 4;
  localparam logic        RL = 1'b0;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout;
  logic dbusy;

  int errors = 0;
  int checks = 0;

  // Reference model: a pure delay line of raw samples plus a count of how many
  // consecutive synchronized samples have disagreed with the accepted level.
  logic m_q[$];
  logic m_out;
  int   m_run;
  int   rises;
  logic prev_out;

  always #5 clk = ~clk;

  debouncer #(
    .SYNC_STAGES (SS),
    .BOUNCE_TICKS(BT),
    .RESET_LEVEL (RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout),
    .busy(dbusy)
  );

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < int'(SS); i++) m_q.push_back(RL);
    m_out = RL;
    m_run = 0;
  endtask

  task automatic model_edge();
    logic s;
    s = m_q.pop_front();
    m_q.push_back(din);
    if (s !== m_out) begin
      m_run++;
      if (m_run == int'(BT) + 1) begin
        m_out = ~m_out;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one raw sample, advance one clock, then compare against the model.
  task automatic tick(input logic v);
    din = v;
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    if (dout === 1'b1 && prev_out === 1'b0) rises++;
    prev_out = dout;
    check("model_out", dout, m_out);
    check("model_busy", dbusy, (m_run != 0));
  endtask

  initial begin
    logic v;
    int   len;
    rises    = 0;
    prev_out = RL;

    // 1 Reset with input high, then release with input low.
    rst = 1'b1;
    din = 1'b1;
    model_reset();
    #1;
    check("reset_out_async", dout, 1'b0);
    check("reset_busy_async", dbusy, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1);
    din = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      check("reset_release_out", dout, 1'b0);
    end

    // 2 Clean rise: busy over ticks 2..5, out from tick 6.
    for (int i = 0; i < 9; i++) begin
      tick(1'b1);
      check("rise_out", dout, (i >= 6));
      check("rise_busy", dbusy, (i >= 2 && i <= 5));
    end
    for (int i = 0; i < 10; i++) tick(1'b0);
    check("back_low", dout, 1'b0);

    // 3 Glitch of exactly BOUNCE_TICKS samples never reaches out.
    for (int i = 0; i < 12; i++) begin
      tick(i < 4);
      check("glitch_out", dout, 1'b0);
      check("glitch_busy", dbusy, (i >= 2 && i <= 5));
    end

    // 4 Minimum accepted pulse: rise at tick 6, fall 6 ticks after input drops.
    for (int i = 0; i < 16; i++) begin
      tick(i < 5);
      check("minpulse_out", dout, (i >= 6 && i < 11));
    end

    // 5 Bounce train of 2-cycle segments, then held high: exactly one rise.
    rises = 0;
    for (int t = 0; t < 10; t++) begin
      tick((t % 2) == 0);
      tick((t % 2) == 0);
      check("bounce_hold_low", dout, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      check("bounce_final_out", dout, (i >= 6));
    end
    checks++;
    assert (rises == 1) else begin
      errors++;
      $error("FAIL bounce_rise_count: observed=%0d expected=1", rises);
    end
    for (int i = 0; i < 10; i++) tick(1'b0);

    // 6 Reset during MAYBE_HIGH, then full re-qualification of the held input.
    for (int i = 0; i < 5; i++) tick(1'b1);
    check("pre_rst_busy", dbusy, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_out", dout, 1'b0);
    check("midrst_busy", dbusy, 1'b0);
    tick(1'b1);
    tick(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick(1'b1);
      check("requal_out", dout, (i >= 6));
    end

    // Random bounce segments with occasional asynchronous resets.
    v = 1'b1;
    for (int seg = 0; seg < 400; seg++) begin
      v   = ~v;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) tick(v);
      if ($urandom_range(0, 39) == 0) begin
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("rand_rst_out", dout, RL);
        check("rand_rst_busy", dbusy, 1'b0);
        tick(v);
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
